// File: rtl/reg_skid.sv
// reg_skid: valid/ready pipeline register with a 2-entry skid buffer, registered in_ready,
// synchronous flush and a wrapping output-transfer counter.
module reg_skid #(
    parameter int             WIDTH     = 64,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int             CNT_W     = 16
) (
    input  logic             clock,
    input  logic             r,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] read_out,
    output logic [CNT_W-1:0] xfer_count
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   main_q, main_d, skid_q, skid_d;
    logic               rdy_q, rdy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_xfer, out_xfer;

    assign in_ready   = rdy_q;
    assign out_valid  = state_q != EMPTY;
    assign read_out   = main_q;
    assign xfer_count = cnt_q;
    assign in_xfer    = in_valid & rdy_q;
    assign out_xfer   = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        rdy_d   = rdy_q;
        cnt_d   = cnt_q + CNT_W'(out_xfer & ~flush);
        // flush overrides every handshake; data registers keep their contents
        if (flush) begin
            state_d = EMPTY;
            rdy_d   = 1'b1;
        end else begin
            case (state_q)
                EMPTY: if (in_xfer) begin
                    main_d  = data_in;
                    state_d = ONE;
                end
                ONE: if (in_xfer && out_ready) begin
                    main_d = data_in;
                end else if (in_xfer) begin
                    skid_d  = data_in;
                    state_d = TWO;
                    rdy_d   = 1'b0;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
                TWO: if (out_ready) begin
                    main_d  = skid_q;
                    state_d = ONE;
                    rdy_d   = 1'b1;
                end
                default: begin
                    state_d = EMPTY;
                    rdy_d   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge r) begin
        if (r) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
            rdy_q   <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_reg_skid.sv
// tb_reg_skid: directed checks on a 64-bit/4-bit-counter instance and a scoreboarded
// random run on an 8-bit instance.
module tb_reg_skid;
    logic        clock = 1'b0;
    logic        r = 1'b0;
    logic        a_flush = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [63:0] a_data_in = '0;
    logic        a_in_ready, a_out_valid;
    logic [63:0] a_read_out;
    logic [3:0]  a_xfer_count;
    logic        b_flush = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [7:0]  b_data_in = '0;
    logic        b_in_ready, b_out_valid;
    logic [7:0]  b_read_out;
    logic [15:0] b_xfer_count;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clock = ~clock;

    reg_skid #(.WIDTH(64), .RESET_VAL(64'hDEAD_BEEF), .CNT_W(4)) dut_a (
        .clock(clock), .r(r), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .data_in(a_data_in), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .read_out(a_read_out), .xfer_count(a_xfer_count)
    );

    reg_skid #(.WIDTH(8), .CNT_W(16)) dut_b (
        .clock(clock), .r(r), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .data_in(b_data_in), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .read_out(b_read_out), .xfer_count(b_xfer_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic mid_reset();
        @(posedge clock);
        #3 r = 1'b1;
        #1;
        check("rst_read_out", a_read_out, 64'hDEAD_BEEF);
        check("rst_out_valid", a_out_valid, 0);
        check("rst_in_ready", a_in_ready, 1);
        check("rst_xfer_count", a_xfer_count, 0);
        @(negedge clock);
        r = 1'b0;
    endtask

    logic [7:0] sb[$];
    logic [7:0] prev_out;
    logic       stalled;
    int         pops;

    task automatic b_cycle(input logic iv, input logic ordy, input logic [7:0] d);
        b_in_valid  = iv;
        b_out_ready = ordy;
        b_data_in   = d;
        if (stalled && b_out_valid) check("b_stable", b_read_out, prev_out);
        if (iv && b_in_ready) sb.push_back(d);
        if (b_out_valid && ordy) begin
            if (sb.size() == 0) check("b_extra_word", 1, 0);
            else check("b_order", b_read_out, sb.pop_front());
            pops++;
        end
        stalled  = b_out_valid && !ordy;
        prev_out = b_read_out;
        tick();
    endtask

    initial begin
        pops = 0;
        stalled = 1'b0;
        prev_out = '0;
        mid_reset();
        // streaming
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_data_in = 64'h1;
        tick();
        check("s1_data", a_read_out, 64'h1);
        check("s1_valid", a_out_valid, 1);
        a_data_in = 64'h2;
        tick();
        check("s2_data", a_read_out, 64'h2);
        a_data_in = 64'h3;
        tick();
        check("s3_data", a_read_out, 64'h3);
        check("s3_valid", a_out_valid, 1);
        a_in_valid = 1'b0;
        tick();
        check("s_count", a_xfer_count, 3);
        check("s_empty", a_out_valid, 0);
        // back-pressure
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_data_in = 64'hA;
        tick();
        check("bp_a_ready", a_in_ready, 1);
        a_data_in = 64'hB;
        tick();
        check("bp_two_ready", a_in_ready, 0);
        check("bp_hold_a", a_read_out, 64'hA);
        a_data_in = 64'hC;
        tick();
        check("bp_still_a", a_read_out, 64'hA);
        check("bp_still_valid", a_out_valid, 1);
        a_in_valid = 1'b0;
        a_out_ready = 1'b1;
        tick();
        check("bp_then_b", a_read_out, 64'hB);
        check("bp_ready_back", a_in_ready, 1);
        check("bp_cnt4", a_xfer_count, 4);
        tick();
        check("bp_drained", a_out_valid, 0);
        check("bp_cnt5", a_xfer_count, 5);
        // flush while holding two words
        a_out_ready = 1'b0;
        a_in_valid = 1'b1;
        a_data_in = 64'hA;
        tick();
        a_data_in = 64'hB;
        tick();
        check("fl_pre_two", a_in_ready, 0);
        a_flush = 1'b1;
        a_data_in = 64'hC;
        a_out_ready = 1'b1;
        tick();
        check("fl_valid", a_out_valid, 0);
        check("fl_ready", a_in_ready, 1);
        check("fl_count", a_xfer_count, 5);
        check("fl_keep_data", a_read_out, 64'hA);
        a_flush = 1'b0;
        a_in_valid = 1'b0;
        a_out_ready = 1'b0;
        tick();
        check("fl_no_c", a_out_valid, 0);
        // reset clears a nonzero count; then wrap the 4-bit counter
        mid_reset();
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            a_data_in = 64'(i);
            tick();
        end
        check("wr_last_data", a_read_out, 64'd17);
        a_in_valid = 1'b0;
        tick();
        check("wr_count", a_xfer_count, 1);
        // random stream on the 8-bit instance
        for (int i = 0; i < 400; i++)
            b_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0), 8'($urandom));
        for (int i = 0; i < 4; i++) b_cycle(1'b0, 1'b1, 8'h00);
        check("b_leftover", sb.size(), 0);
        check("b_count", b_xfer_count, pops);
        check("b_final_empty", b_out_valid, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/reg_skid.md
Name: reg_skid

Overview:
- Parametrised successor to the team's fixed 64-bit always-enabled pipeline register.
- Adds a valid/ready handshake with a 2-entry skid buffer, a synchronous flush, a configurable reset value and a wrapping transfer counter.
- Sits between pipeline stages (game-logic datapath, processor stage boundaries), so a stalled consumer back-pressures the producer without dropping or duplicating words.
- in_ready is registered, which breaks the combinational ready path between stages.

Parameters:
- WIDTH, 64, data width in bits (1..128).
- RESET_VAL, 0, value loaded into both data registers on reset (WIDTH bits, zero-extended).
- CNT_W, 16, width of the transfer counter.

Ports:
- clock  in  1  single clock; all state updates on the rising edge.
- r  in  1  reset, asynchronous, active-high.
- flush  in  1  synchronous discard of all buffered words.
- in_valid  in  1  producer has a word on data_in.
- in_ready  out  1  registered; buffer can accept a word this cycle.
- data_in  in  WIDTH  producer data.
- out_valid  out  1  read_out holds a valid word.
- out_ready  in  1  consumer accepts read_out this cycle.
- read_out  out  WIDTH  output data, driven directly from the main register.
- xfer_count  out  CNT_W  number of output transfers since reset, modulo 2^CNT_W.

Behaviour:
- Transfers: an input transfer occurs when in_valid & in_ready at a clock edge. An output transfer occurs when out_valid & out_ready.
- Storage: main register (drives read_out) and skid register.
- State machine: EMPTY (0 words), ONE (main valid), TWO (main + skid valid).
- Output decoding: out_valid = (state != EMPTY). in_ready is a flop: 1 in EMPTY/ONE, 0 in TWO, and updated on the same edge as the state.
- Reset (r=1, async):
  - state=EMPTY, in_ready=1, out_valid=0.
  - main=skid=RESET_VAL, so read_out=RESET_VAL.
  - xfer_count=0.
  - Reset mid-transfer discards all words; nothing partial survives.
- flush=1 (sync, highest priority over all handshake events):
  - next state EMPTY, in_ready=1.
  - Data registers are not rewritten; read_out keeps its last value while out_valid=0.
  - An input or output transfer in the flush cycle is discarded and not counted.
- EMPTY:
  - in_valid: main<=data_in, go to ONE. Latency is 1 cycle from input transfer to out_valid.
  - otherwise stay.
- ONE:
  - in_valid & out_ready: main<=data_in, stay in ONE (full throughput, 1 word/cycle).
  - in_valid & !out_ready: skid<=data_in, go to TWO, in_ready becomes 0 next cycle.
  - !in_valid & out_ready: go to EMPTY.
  - neither: hold.
- TWO:
  - out_ready: main<=skid, go to ONE, in_ready becomes 1.
  - in_valid is ignored because in_ready=0.
  - otherwise hold all state; read_out stays stable.
- Handshake rules:
  - read_out and out_valid must not change while out_valid=1 & out_ready=0 (except on flush or reset).
  - Words leave in arrival order; no drop, no duplicate.
- Counter: xfer_count increments by 1 on each output transfer, wraps from 2^CNT_W-1 to 0, and is not cleared by flush.
- Width rules: RESET_VAL is truncated or zero-extended to WIDTH. Data is passed unmodified.
- No combinational path from out_ready or in_valid to in_ready.

Test Plan:
- Reset: assert r mid-cycle with RESET_VAL=64'hDEAD_BEEF -> immediately read_out=64'hDEAD_BEEF, out_valid=0, in_ready=1, xfer_count=0.
- Streaming: out_ready=1, send 0x1,0x2,0x3 on consecutive cycles -> read_out 0x1,0x2,0x3 one cycle later each, out_valid continuous, xfer_count=3.
- Back-pressure: out_ready=0, send 0xA then 0xB -> state TWO, in_ready=0, read_out=0xA held. Raise out_ready -> 0xA then 0xB delivered in order, in_ready returns to 1 after the first.
- Flush in TWO holding 0xA/0xB with in_valid=1, data_in=0xC -> next cycle out_valid=0, in_ready=1, 0xC not captured, xfer_count unchanged.
- Counter wrap: CNT_W=4, perform 17 output transfers -> xfer_count=1.
- Randomised in_valid/out_ready with WIDTH=8 against a scoreboard -> output sequence equals input sequence, no extra words and no missing words.
